atm_keypad_frontend: RTL and testbench
======================================

// Module: atm_keypad_frontend
// PURPOSE
//  Keypad front end sitting directly upstream of the ATM controller. Debounces raw key presses.
//  Sequences the session (PIN -> transaction select -> amount) and produces the controller's
//  digito/digito_stb, tipo_trans and monto/monto_stb inputs. Tracks controller outcome flags to
//  know when to re-enter the PIN, end the session or lock.
// PARAMETERS
//  DEBOUNCE_CYCLES  4  consecutive stable cycles needed to accept a press or a release
//  PIN_DIGITS       4  digits forwarded per PIN attempt
//  MAX_MONTO_DIG    9  maximum amount digits (10^9-1 fits in 32 bits, so overflow cannot occur)
// PORTS
//  clk                   in   1   single clock; all logic on posedge
//  rst                   in   1   synchronous, active-high reset
//  tecla_raw             in   1   raw key-down level (may bounce)
//  tecla_cod             in   4   raw key code: 0-9 digit, 10 DEPOSITO, 11 RETIRO, 14 ENTER, 15 BORRAR
//  tarjeta_recibida      in   1   card inserted; starts a session
//  pin_incorrecto        in   1   from controller: PIN attempt rejected
//  bloqueo               in   1   from controller: card blocked
//  balance_actualizado   in   1   from controller: deposit done
//  entregar_dinero       in   1   from controller: withdrawal done
//  fondos_insuficientes  in   1   from controller: withdrawal rejected
//  digito                out  4   PIN digit, valid while digito_stb=1
//  digito_stb            out  1   one-cycle PIN digit strobe
//  tipo_trans            out  1   0 deposit, 1 withdrawal; held until next selection or reset
//  monto                 out  32  binary amount; held after the strobe
//  monto_stb             out  1   one-cycle amount strobe
//  tecla_error           out  1   one-cycle pulse on a rejected or illegal key
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; counters and accumulator cleared; debouncer disarmed.
//  Debounce:
//   - Press event fires when tecla_raw=1 with unchanged tecla_cod for DEBOUNCE_CYCLES consecutive cycles.
//   - Exactly one event per press.
//   - Re-arm requires tecla_raw=0 for DEBOUNCE_CYCLES cycles.
//   - A code change while pressed restarts the count.
//  Latency: press event in cycle t -> strobe/tecla_error registered high in cycle t+1, for 1 cycle only.
//  FSM states: IDLE, PIN, SEL, MONTO, ESPERA, BLOQ.
//   IDLE:   keys ignored (no error). tarjeta_recibida -> PIN, pin_cnt=0.
//   PIN:    digit -> digito=code, digito_stb pulse, pin_cnt++; on the PIN_DIGITS-th digit -> SEL.
//           Non-digit -> tecla_error.
//   SEL:    10 -> tipo_trans=0, MONTO, acc=0, ndig=0. 11 -> tipo_trans=1, same.
//           Other keys -> tecla_error.
//   MONTO:  digit with ndig<MAX_MONTO_DIG -> acc=acc*10+code (32-bit), ndig++.
//           Digit at the limit -> tecla_error, acc unchanged.
//           15 -> acc=0, ndig=0.
//           14 with ndig>0 -> monto=acc, monto_stb pulse, ESPERA. 14 with ndig=0 -> tecla_error.
//   ESPERA: keys ignored. balance_actualizado | entregar_dinero | fondos_insuficientes -> IDLE.
//   BLOQ:   all inputs ignored until rst.
//  Controller flags in any of PIN/SEL/MONTO/ESPERA:
//   - bloqueo -> BLOQ.
//   - pin_incorrecto -> PIN with pin_cnt=0; tipo_trans and acc are kept.
//  Priority within one cycle: rst > bloqueo > pin_incorrecto > completion flags > key event.
//   - A key event coinciding with a state-changing flag is dropped (no strobe, no error).
//  tarjeta_recibida outside IDLE: ignored.
//  Codes 12 and 13: illegal in every active state -> tecla_error.
//  Reset mid-session: returns to IDLE next cycle; a key still held must be released before any new event.
// STRUCTURE
//  Package atm_pkg:
//   - key-code localparams: K_DEPOSITO=10, K_RETIRO=11, K_ENTER=14, K_BORRAR=15
//   - FSM state encoding (3 bits)
//   - TIPO_DEPOSITO=0, TIPO_RETIRO=1
//  Sub-module keypad_debouncer (params DEBOUNCE_CYCLES):
//   - inputs clk, rst, tecla_raw, tecla_cod
//   - outputs tecla_evt (1-cycle), tecla_val[3:0]
//  Top holds the FSM, PIN counter, amount accumulator (acc*10 as (acc<<3)+(acc<<1)) and output registers.
// TESTING
//  1 Bounce: tecla_raw toggles 1/0 every cycle for 10 cycles, then holds 1 with code 4 for 4 cycles
//    -> exactly one event; digito=4 with digito_stb=1 for one cycle.
//  2 Happy deposit: card; digits 4,7,5,6; key 10; keys 1,0,0,0,0; ENTER
//    -> four digito_stb pulses carrying 4,7,5,6; tipo_trans=0; monto=10000 with one monto_stb;
//       balance_actualizado -> IDLE.
//  3 Retry: card; 4,7,5,7; pin_incorrecto
//    -> PIN state with pin_cnt=0; then 4,7,5,6; key 11; 1,0,0,0; ENTER -> tipo_trans=1, monto=1000.
//  4 Amount edits: in MONTO, 9,9 then 15 then 5 then ENTER -> monto=5.
//    ENTER at ndig=0 -> tecla_error, no monto_stb.
//    Ten 9s -> monto=999999999, 10th digit raises tecla_error.
//  5 Lock: bloqueo during PIN -> keys give no strobes or errors; rst -> all outputs 0, state IDLE.
//  6 Collisions: key event same cycle as pin_incorrecto -> no strobe.
//    Codes 12/13 in SEL -> tecla_error.
//    tarjeta_recibida in MONTO -> ignored.

Source files
------------

// File: rtl/atm_pkg.sv
// Shared key codes, FSM encoding and transaction types for the ATM keypad front end.
package atm_pkg;
    localparam logic [3:0] K_DEPOSITO = 4'd10;
    localparam logic [3:0] K_RETIRO   = 4'd11;
    localparam logic [3:0] K_ENTER    = 4'd14;
    localparam logic [3:0] K_BORRAR   = 4'd15;

    localparam logic TIPO_DEPOSITO = 1'b0;
    localparam logic TIPO_RETIRO   = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PIN    = 3'd1,
        ST_SEL    = 3'd2,
        ST_MONTO  = 3'd3,
        ST_ESPERA = 3'd4,
        ST_BLOQ   = 3'd5
    } atm_state_t;

    function automatic logic is_digit(input logic [3:0] c);
        return c <= 4'd9;
    endfunction

    function automatic logic is_illegal(input logic [3:0] c);
        return (c == 4'd12) || (c == 4'd13);
    endfunction
endpackage

// File: rtl/keypad_debouncer.sv
// Turns a bouncing key level plus code into one registered event per stable press.
module keypad_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tecla_raw,
    input  logic [3:0] tecla_cod,
    output logic       tecla_evt,
    output logic [3:0] tecla_val
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DC = CW'(DEBOUNCE_CYCLES);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic [3:0]    last_cod;
    logic          armed;

    assign cnt_nx = cnt + 1'b1;

    // armed=1: counting a stable press; armed=0: counting a stable release.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            last_cod  <= '0;
            armed     <= 1'b0;
            tecla_evt <= 1'b0;
            tecla_val <= '0;
        end else begin
            tecla_evt <= 1'b0;
            if (armed) begin
                if (tecla_raw) begin
                    last_cod <= tecla_cod;
                    if (cnt != '0 && tecla_cod == last_cod) begin
                        if (cnt_nx == DC) begin
                            tecla_evt <= 1'b1;
                            tecla_val <= tecla_cod;
                            armed     <= 1'b0;
                            cnt       <= '0;
                        end else begin
                            cnt <= cnt_nx;
                        end
                    end else begin
                        cnt <= CW'(1);
                    end
                end else begin
                    cnt <= '0;
                end
            end else begin
                if (!tecla_raw) begin
                    if (cnt_nx == DC) begin
                        armed <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_nx;
                    end
                end else begin
                    cnt <= '0;
                end
            end
        end
    end
endmodule

// File: rtl/atm_keypad_frontend.sv
// Session sequencer between the keypad and the ATM controller: PIN, transaction select, amount.
module atm_keypad_frontend
    import atm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PIN_DIGITS      = 4,
    parameter int MAX_MONTO_DIG   = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tecla_raw,
    input  logic [3:0]  tecla_cod,
    input  logic        tarjeta_recibida,
    input  logic        pin_incorrecto,
    input  logic        bloqueo,
    input  logic        balance_actualizado,
    input  logic        entregar_dinero,
    input  logic        fondos_insuficientes,
    output logic [3:0]  digito,
    output logic        digito_stb,
    output logic        tipo_trans,
    output logic [31:0] monto,
    output logic        monto_stb,
    output logic        tecla_error
);
    localparam int PCW = $clog2(PIN_DIGITS + 1);
    localparam logic [PCW-1:0] PIN_LAST = PCW'(PIN_DIGITS - 1);
    localparam logic [3:0]     NDIG_MAX = 4'(MAX_MONTO_DIG);

    atm_state_t     state;
    logic [PCW-1:0] pin_cnt;
    logic [3:0]     ndig;
    logic [31:0]    acc;
    logic [31:0]    acc_nx;
    logic           tecla_evt;
    logic [3:0]     tecla_val;
    logic           done;

    keypad_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .clk       (clk),
        .rst       (rst),
        .tecla_raw (tecla_raw),
        .tecla_cod (tecla_cod),
        .tecla_evt (tecla_evt),
        .tecla_val (tecla_val)
    );

    assign acc_nx = {acc[28:0], 3'b000} + {acc[30:0], 1'b0} + {28'd0, tecla_val};
    assign done   = balance_actualizado | entregar_dinero | fondos_insuficientes;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            pin_cnt     <= '0;
            ndig        <= '0;
            acc         <= '0;
            digito      <= '0;
            digito_stb  <= 1'b0;
            tipo_trans  <= 1'b0;
            monto       <= '0;
            monto_stb   <= 1'b0;
            tecla_error <= 1'b0;
        end else begin
            digito_stb  <= 1'b0;
            monto_stb   <= 1'b0;
            tecla_error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tarjeta_recibida) begin
                        state   <= ST_PIN;
                        pin_cnt <= '0;
                    end
                end
                ST_BLOQ: ;
                default: begin
                    // Flags outrank keys; a key landing on a flag cycle is dropped.
                    if (bloqueo) begin
                        state <= ST_BLOQ;
                    end else if (pin_incorrecto) begin
                        state   <= ST_PIN;
                        pin_cnt <= '0;
                    end else if (state == ST_ESPERA) begin
                        if (done) state <= ST_IDLE;
                    end else if (tecla_evt) begin
                        if (is_illegal(tecla_val)) begin
                            tecla_error <= 1'b1;
                        end else begin
                            case (state)
                                ST_PIN: begin
                                    if (is_digit(tecla_val)) begin
                                        digito     <= tecla_val;
                                        digito_stb <= 1'b1;
                                        pin_cnt    <= pin_cnt + 1'b1;
                                        if (pin_cnt == PIN_LAST) state <= ST_SEL;
                                    end else begin
                                        tecla_error <= 1'b1;
                                    end
                                end
                                ST_SEL: begin
                                    if (tecla_val == K_DEPOSITO || tecla_val == K_RETIRO) begin
                                        tipo_trans <= (tecla_val == K_RETIRO) ? TIPO_RETIRO : TIPO_DEPOSITO;
                                        state      <= ST_MONTO;
                                        acc        <= '0;
                                        ndig       <= '0;
                                    end else begin
                                        tecla_error <= 1'b1;
                                    end
                                end
                                ST_MONTO: begin
                                    if (is_digit(tecla_val)) begin
                                        if (ndig < NDIG_MAX) begin
                                            acc  <= acc_nx;
                                            ndig <= ndig + 1'b1;
                                        end else begin
                                            tecla_error <= 1'b1;
                                        end
                                    end else if (tecla_val == K_BORRAR) begin
                                        acc  <= '0;
                                        ndig <= '0;
                                    end else if (tecla_val == K_ENTER && ndig != '0) begin
                                        monto     <= acc;
                                        monto_stb <= 1'b1;
                                        state     <= ST_ESPERA;
                                    end else begin
                                        tecla_error <= 1'b1;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_atm_keypad_frontend.sv
// Scoreboard bench: stimulus pushes expected strobes, a monitor pops and compares them.
module tb_atm_keypad_frontend;
    import atm_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tecla_raw = 1'b0;
    logic [3:0]  tecla_cod = 4'd0;
    logic        tarjeta_recibida = 1'b0;
    logic        pin_incorrecto = 1'b0;
    logic        bloqueo = 1'b0;
    logic        balance_actualizado = 1'b0;
    logic        entregar_dinero = 1'b0;
    logic        fondos_insuficientes = 1'b0;
    logic [3:0]  digito;
    logic        digito_stb;
    logic        tipo_trans;
    logic [31:0] monto;
    logic        monto_stb;
    logic        tecla_error;

    atm_keypad_frontend dut (
        .clk                  (clk),
        .rst                  (rst),
        .tecla_raw            (tecla_raw),
        .tecla_cod            (tecla_cod),
        .tarjeta_recibida     (tarjeta_recibida),
        .pin_incorrecto       (pin_incorrecto),
        .bloqueo              (bloqueo),
        .balance_actualizado  (balance_actualizado),
        .entregar_dinero      (entregar_dinero),
        .fondos_insuficientes (fondos_insuficientes),
        .digito               (digito),
        .digito_stb           (digito_stb),
        .tipo_trans           (tipo_trans),
        .monto                (monto),
        .monto_stb            (monto_stb),
        .tecla_error          (tecla_error)
    );

    always #5 clk = ~clk;

    localparam int E_DIG = 0;
    localparam int E_MONTO = 1;
    localparam int E_ERR = 2;

    typedef struct {
        int          kind;
        logic [31:0] val;
        logic        tipo;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, want, want);
    endtask

    task automatic take(input string name, input int kind, input logic [31:0] val, input logic tipo);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s: unexpected output value %0d, nothing expected", name, val);
        end else begin
            e = exp_q.pop_front();
            chk({name, "_kind"}, 32'(kind), 32'(e.kind));
            if (kind == E_DIG || kind == E_MONTO) chk({name, "_val"}, val, e.val);
            if (kind == E_MONTO) chk({name, "_tipo"}, {31'd0, tipo}, {31'd0, e.tipo});
        end
    endtask

    // Monitor: every strobe the DUT presents must match the head of the queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (digito_stb)  take("digito", E_DIG, {28'd0, digito}, 1'b0);
            if (monto_stb)   take("monto", E_MONTO, monto, tipo_trans);
            if (tecla_error) take("tecla_error", E_ERR, 32'd0, 1'b0);
        end
    end

    task automatic push(input int kind, input logic [31:0] val, input logic tipo);
        exp_t e;
        e.kind = kind; e.val = val; e.tipo = tipo;
        exp_q.push_back(e);
    endtask

    task automatic press(input logic [3:0] code);
        @(negedge clk);
        tecla_raw = 1'b1;
        tecla_cod = code;
        repeat (5) @(negedge clk);
        tecla_raw = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic pulse_card();
        @(negedge clk); tarjeta_recibida = 1'b1;
        @(negedge clk); tarjeta_recibida = 1'b0;
    endtask

    task automatic enter_pin(input logic [3:0] d0, input logic [3:0] d1,
                             input logic [3:0] d2, input logic [3:0] d3);
        push(E_DIG, 32'(d0), 1'b0); press(d0);
        push(E_DIG, 32'(d1), 1'b0); press(d1);
        push(E_DIG, 32'(d2), 1'b0); press(d2);
        push(E_DIG, 32'(d3), 1'b0); press(d3);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1; tecla_raw = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_digito"}, {28'd0, digito}, 32'd0);
        chk({tag, "_digito_stb"}, {31'd0, digito_stb}, 32'd0);
        chk({tag, "_tipo"}, {31'd0, tipo_trans}, 32'd0);
        chk({tag, "_monto"}, monto, 32'd0);
        chk({tag, "_monto_stb"}, {31'd0, monto_stb}, 32'd0);
        chk({tag, "_err"}, {31'd0, tecla_error}, 32'd0);
        chk({tag, "_state"}, 32'(dut.state), 32'(ST_IDLE));
    endtask

    initial begin
        do_reset();
        check_outputs_zero("reset");

        // 1 bounce then happy deposit
        pulse_card();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tecla_cod = 4'd4;
            tecla_raw = (i % 2 == 0);
        end
        push(E_DIG, 32'd4, 1'b0);
        @(negedge clk); tecla_raw = 1'b1; tecla_cod = 4'd4;
        repeat (4) @(negedge clk);
        tecla_raw = 1'b0;
        repeat (6) @(negedge clk);
        push(E_DIG, 32'd7, 1'b0); press(4'd7);
        push(E_DIG, 32'd5, 1'b0); press(4'd5);
        push(E_DIG, 32'd6, 1'b0); press(4'd6);
        press(K_DEPOSITO);
        press(4'd1); press(4'd0); press(4'd0); press(4'd0); press(4'd0);
        push(E_MONTO, 32'd10000, TIPO_DEPOSITO); press(K_ENTER);
        @(negedge clk); balance_actualizado = 1'b1;
        @(negedge clk); balance_actualizado = 1'b0;
        @(negedge clk);
        chk("deposit_idle", 32'(dut.state), 32'(ST_IDLE));
        chk("deposit_tipo", {31'd0, tipo_trans}, 32'd0);

        // 3 retry after a wrong PIN
        pulse_card();
        enter_pin(4'd4, 4'd7, 4'd5, 4'd7);
        @(negedge clk); pin_incorrecto = 1'b1;
        @(negedge clk); pin_incorrecto = 1'b0;
        @(negedge clk);
        chk("retry_state", 32'(dut.state), 32'(ST_PIN));
        chk("retry_pin_cnt", 32'(dut.pin_cnt), 32'd0);
        enter_pin(4'd4, 4'd7, 4'd5, 4'd6);
        press(K_RETIRO);
        press(4'd1); press(4'd0); press(4'd0); press(4'd0);
        push(E_MONTO, 32'd1000, TIPO_RETIRO); press(K_ENTER);
        @(negedge clk); entregar_dinero = 1'b1;
        @(negedge clk); entregar_dinero = 1'b0;
        @(negedge clk);
        chk("retiro_idle", 32'(dut.state), 32'(ST_IDLE));
        chk("retiro_tipo_held", {31'd0, tipo_trans}, 32'd1);

        // 4 amount edits, empty ENTER, digit limit
        pulse_card();
        enter_pin(4'd1, 4'd2, 4'd3, 4'd4);
        press(K_DEPOSITO);
        press(4'd9); press(4'd9); press(K_BORRAR); press(4'd5);
        push(E_MONTO, 32'd5, TIPO_DEPOSITO); press(K_ENTER);
        @(negedge clk); fondos_insuficientes = 1'b1;
        @(negedge clk); fondos_insuficientes = 1'b0;
        pulse_card();
        enter_pin(4'd1, 4'd2, 4'd3, 4'd4);
        press(K_RETIRO);
        push(E_ERR, 32'd0, 1'b0); press(K_ENTER);
        for (int i = 0; i < 9; i++) press(4'd9);
        push(E_ERR, 32'd0, 1'b0); press(4'd9);
        push(E_MONTO, 32'd999999999, TIPO_RETIRO); press(K_ENTER);
        @(negedge clk); entregar_dinero = 1'b1;
        @(negedge clk); entregar_dinero = 1'b0;

        // 5 lock, then reset
        pulse_card();
        push(E_DIG, 32'd1, 1'b0); press(4'd1);
        @(negedge clk); bloqueo = 1'b1;
        @(negedge clk); bloqueo = 1'b0;
        press(4'd2); press(4'd12); press(K_ENTER);
        chk("lock_state", 32'(dut.state), 32'(ST_BLOQ));
        do_reset();
        check_outputs_zero("post_lock_reset");

        // 6 collisions: key event on the same cycle as pin_incorrecto
        pulse_card();
        push(E_DIG, 32'd4, 1'b0); press(4'd4);
        push(E_DIG, 32'd7, 1'b0); press(4'd7);
        @(negedge clk); tecla_raw = 1'b1; tecla_cod = 4'd3;
        repeat (4) @(negedge clk);
        pin_incorrecto = 1'b1;
        @(negedge clk); pin_incorrecto = 1'b0; tecla_raw = 1'b0;
        repeat (6) @(negedge clk);
        chk("collide_pin_cnt", 32'(dut.pin_cnt), 32'd0);
        enter_pin(4'd4, 4'd7, 4'd5, 4'd6);
        push(E_ERR, 32'd0, 1'b0); press(4'd12);
        push(E_ERR, 32'd0, 1'b0); press(4'd13);
        press(K_DEPOSITO);
        pulse_card();
        @(negedge clk);
        chk("card_in_monto", 32'(dut.state), 32'(ST_MONTO));
        press(4'd3);
        push(E_MONTO, 32'd3, TIPO_DEPOSITO); press(K_ENTER);
        @(negedge clk); balance_actualizado = 1'b1;
        @(negedge clk); balance_actualizado = 1'b0;
        repeat (4) @(negedge clk);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, %0d expected outputs pending", exp_q.size());
        $fatal(1, "timeout");
    end
endmodule
